// File: rtl/wash_cycle_sequencer.sv
// Washing-machine state sequencer: decodes panel buttons and the lid sensor into the state bus,
// selects the program word and closes the loop on the run controller's status signals.
module wash_cycle_sequencer #(
    parameter int          NUM_MODES = 4,
    parameter logic [25:0] PROG0     = {3'd1, 4'd2, 3'd1, 3'd1, 3'd1, 4'd2, 3'd1, 3'd1},
    parameter logic [25:0] PROG1     = {3'd0, 4'd1, 3'd0, 3'd1, 3'd0, 4'd1, 3'd0, 3'd1},
    parameter logic [25:0] PROG2     = {3'd3, 4'd9, 3'd3, 3'd3, 3'd3, 4'd9, 3'd3, 3'd3},
    parameter logic [25:0] PROG3     = {3'd0, 4'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd2, 3'd2}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_btn,
    input  logic        start_btn,
    input  logic        mode_btn,
    input  logic        lid_open,
    input  logic        had_finish,
    input  logic [2:0]  init_time,
    input  logic [2:0]  finish_time,
    output logic [2:0]  state,
    output logic [25:0] data,
    output logic [1:0]  mode,
    output logic        buzzer
);

    typedef enum logic [2:0] {
        ST_SHUTDOWN = 3'd0,
        ST_BEGIN    = 3'd1,
        ST_SET      = 3'd2,
        ST_RUN      = 3'd3,
        ST_ERROR    = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_FINISH   = 3'd6
    } state_t;

    localparam logic [25:0] PROG_TABLE [4] = '{PROG0, PROG1, PROG2, PROG3};
    localparam logic [1:0]  LAST_MODE      = 2'(NUM_MODES - 1);

    state_t      state_reg, state_next;
    logic [1:0]  mode_reg, mode_next;
    logic [25:0] data_reg;
    logic        buzzer_reg, buzzer_next;
    logic        power_prev_reg, start_prev_reg, mode_prev_reg;
    logic        power_edge, start_edge, mode_edge;

    assign power_edge = power_btn & ~power_prev_reg;
    assign start_edge = start_btn & ~start_prev_reg;
    assign mode_edge  = mode_btn  & ~mode_prev_reg;

    // State register. During reset the button copies track the live levels so that a button
    // still held when reset releases is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
        power_prev_reg <= power_btn;
        start_prev_reg <= start_btn;
        mode_prev_reg  <= mode_btn;
        if (rst) begin
            state_reg  <= ST_SHUTDOWN;
            mode_reg   <= 2'd0;
            data_reg   <= PROG0;
            buzzer_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            data_reg   <= PROG_TABLE[mode_reg];
            buzzer_reg <= buzzer_next;
        end
    end

    // Next-state logic; power edge outranks everything, then lid, start, and status inputs.
    always_comb begin
        state_next = state_reg;
        if (state_reg != ST_SHUTDOWN && power_edge) begin
            state_next = ST_SHUTDOWN;
        end else begin
            case (state_reg)
                ST_SHUTDOWN: if (power_edge) state_next = ST_BEGIN;
                ST_BEGIN:    if (init_time == 3'd0) state_next = ST_SET;
                ST_SET:      if (start_edge) state_next = lid_open ? ST_ERROR : ST_RUN;
                ST_RUN: begin
                    if (lid_open)        state_next = ST_ERROR;
                    else if (start_edge) state_next = ST_PAUSE;
                    else if (had_finish) state_next = ST_FINISH;
                end
                ST_PAUSE:    if (start_edge && !lid_open) state_next = ST_RUN;
                ST_ERROR:    if (start_edge && !lid_open) state_next = ST_SET;
                ST_FINISH:   if (finish_time == 3'd0) state_next = ST_SHUTDOWN;
                default:     state_next = ST_SHUTDOWN;
            endcase
        end
    end

    // Output logic: mode steps only in SET when no higher-priority button acted this cycle.
    always_comb begin
        mode_next   = mode_reg;
        buzzer_next = (state_next == ST_FINISH) || (state_next == ST_ERROR);
        if (state_next == ST_SHUTDOWN) begin
            mode_next = 2'd0;
        end else if (state_reg == ST_SET && !power_edge && !start_edge && mode_edge) begin
            mode_next = (mode_reg == LAST_MODE) ? 2'd0 : mode_reg + 2'd1;
        end
    end

    assign state  = state_reg;
    assign mode   = mode_reg;
    assign data   = data_reg;
    assign buzzer = buzzer_reg;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Scoreboard bench for wash_cycle_sequencer: each driven cycle pushes its expected outputs,
// which are popped and compared just after the clock edge that should produce them.
module tb_wash_cycle_sequencer;

    localparam logic [25:0] P0 = {3'd1, 4'd2, 3'd1, 3'd1, 3'd1, 4'd2, 3'd1, 3'd1};
    localparam logic [25:0] P1 = {3'd0, 4'd1, 3'd0, 3'd1, 3'd0, 4'd1, 3'd0, 3'd1};
    localparam logic [25:0] P2 = {3'd3, 4'd9, 3'd3, 3'd3, 3'd3, 4'd9, 3'd3, 3'd3};
    localparam logic [25:0] P3 = {3'd0, 4'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd2, 3'd2};

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  md;
        logic [25:0] dt;
        logic        bz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        power_btn = 1'b0, start_btn = 1'b0, mode_btn = 1'b0, lid_open = 1'b0;
    logic        had_finish = 1'b0;
    logic [2:0]  init_time = 3'd0, finish_time = 3'd1;
    logic [2:0]  state;
    logic [25:0] data;
    logic [1:0]  mode;
    logic        buzzer;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_idx = 0;

    wash_cycle_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .power_btn   (power_btn),
        .start_btn   (start_btn),
        .mode_btn    (mode_btn),
        .lid_open    (lid_open),
        .had_finish  (had_finish),
        .init_time   (init_time),
        .finish_time (finish_time),
        .state       (state),
        .data        (data),
        .mode        (mode),
        .buzzer      (buzzer)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL step=%0d %s got=0x%0h expected=0x%0h", step_idx, tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next edge, then compare.
    task automatic step(input logic pw, input logic st, input logic md, input logic ld,
                        input logic hf, input logic [2:0] it, input logic [2:0] ft,
                        input logic [2:0] es, input logic [1:0] em, input logic [25:0] ed,
                        input logic eb);
        exp_t e;
        power_btn   = pw;
        start_btn   = st;
        mode_btn    = md;
        lid_open    = ld;
        had_finish  = hf;
        init_time   = it;
        finish_time = ft;
        e.st = es;
        e.md = em;
        e.dt = ed;
        e.bz = eb;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("state",  32'(state),  32'(e.st));
        check_val("mode",   32'(mode),   32'(e.md));
        check_val("data",   32'(data),   32'(e.dt));
        check_val("buzzer", 32'(buzzer), 32'(e.bz));
        $display("step %0d: pw=%0b st=%0b md=%0b lid=%0b hf=%0b it=%0d ft=%0d -> state=%0d mode=%0d data=0x%07h buzzer=%0b",
                 step_idx, pw, st, md, ld, hf, it, ft, state, mode, data, buzzer);
        step_idx++;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(0,0,0,0,0,3'd0,3'd1, 3'd0,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd0,2'd0,P0,0);
        rst = 1'b0;

        // T1: SHUTDOWN ignores all but power; BEGIN waits for init_time==0
        step(0,0,0,0,0,3'd0,3'd1, 3'd0,2'd0,P0,0);
        step(0,1,1,0,1,3'd0,3'd0, 3'd0,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd0,2'd0,P0,0);
        step(1,0,0,0,0,3'd5,3'd1, 3'd1,2'd0,P0,0);
        for (int i = 5; i >= 1; i--)
            step(0,0,0,0,0,3'(i),3'd1, 3'd1,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd0,P0,0);

        // T2: mode presses with wrap, data lags mode by one cycle, held button steps once
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd1,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd1,P1,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd2,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd2,P2,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd3,P2,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd3,P3,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd0,P3,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd0,P0,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd1,P0,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd1,P1,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd1,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd1,P1,0);

        // T3: RUN / PAUSE / RUN / FINISH / SHUTDOWN; mode press ignored in RUN
        step(0,1,0,0,0,3'd0,3'd1, 3'd3,2'd1,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd3,2'd1,P1,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd3,2'd1,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd3,2'd1,P1,0);
        step(0,1,0,0,0,3'd0,3'd1, 3'd5,2'd1,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd5,2'd1,P1,0);
        step(0,1,0,0,0,3'd0,3'd1, 3'd3,2'd1,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd3,2'd1,P1,0);
        step(0,0,0,0,1,3'd0,3'd1, 3'd6,2'd1,P1,1);
        step(0,0,0,0,0,3'd0,3'd2, 3'd6,2'd1,P1,1);
        step(0,0,0,0,0,3'd0,3'd0, 3'd0,2'd0,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd0,2'd0,P0,0);

        // T4: lid opens in RUN -> ERROR; start with lid open is ignored; closed + start -> SET
        step(1,0,0,0,0,3'd0,3'd1, 3'd1,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd0,P0,0);
        step(0,1,0,0,0,3'd0,3'd1, 3'd3,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd3,2'd0,P0,0);
        step(0,0,0,1,0,3'd0,3'd1, 3'd4,2'd0,P0,1);
        step(0,1,0,1,0,3'd0,3'd1, 3'd4,2'd0,P0,1);
        step(0,0,0,1,0,3'd0,3'd1, 3'd4,2'd0,P0,1);
        step(0,0,0,0,0,3'd0,3'd1, 3'd4,2'd0,P0,1);
        step(0,1,0,0,0,3'd0,3'd1, 3'd2,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd0,P0,0);
        step(0,1,0,1,0,3'd0,3'd1, 3'd4,2'd0,P0,1);
        step(0,0,0,0,0,3'd0,3'd1, 3'd4,2'd0,P0,1);
        step(0,1,0,0,0,3'd0,3'd1, 3'd2,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd0,P0,0);

        // T5: start and had_finish together in RUN -> PAUSE; lid in PAUSE holds; power -> SHUTDOWN
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd1,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd1,P1,0);
        step(0,1,0,0,0,3'd0,3'd1, 3'd3,2'd1,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd3,2'd1,P1,0);
        step(0,1,0,0,1,3'd0,3'd1, 3'd5,2'd1,P1,0);
        step(0,0,0,0,1,3'd0,3'd1, 3'd5,2'd1,P1,0);
        step(0,0,0,1,0,3'd0,3'd1, 3'd5,2'd1,P1,0);
        step(0,1,0,1,0,3'd0,3'd1, 3'd5,2'd1,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd5,2'd1,P1,0);
        step(1,0,0,0,0,3'd0,3'd1, 3'd0,2'd0,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd0,2'd0,P0,0);

        // T6: reset during RUN with buttons and lid active; held buttons are not edges afterwards
        step(1,0,0,0,0,3'd0,3'd1, 3'd1,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd0,P0,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd1,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd1,P1,0);
        step(0,0,1,0,0,3'd0,3'd1, 3'd2,2'd2,P1,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd2,2'd2,P2,0);
        step(0,1,0,0,0,3'd0,3'd1, 3'd3,2'd2,P2,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd3,2'd2,P2,0);
        rst = 1'b1;
        step(1,1,1,1,1,3'd0,3'd1, 3'd0,2'd0,P0,0);
        rst = 1'b0;
        step(1,1,1,1,1,3'd0,3'd1, 3'd0,2'd0,P0,0);
        step(0,0,0,0,0,3'd0,3'd1, 3'd0,2'd0,P0,0);
        step(1,0,0,0,0,3'd0,3'd1, 3'd1,2'd0,P0,0);

        if (sb_q.size() != 0) check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
